csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL provide parameter HARTID, default 0, value returned on reads of mhartid (0xf14).
REQ-002 SHALL provide parameter MTVEC_RST, default 64'h0, reset value of mtvec.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock); rst_n (input, 1, active-low reset).
REQ-004 SHALL have ports: req_valid in 1 (access request); req_ready out 1 (request accepted); req_op in 2 (01 RW, 10 RS, 11 RC, 00 illegal); req_addr in 12 (CSR address); req_wdata in 64 (operand).
REQ-005 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out 64 (pre-write CSR value); resp_illegal out 1 (access rejected).
REQ-006 SHALL have ports: trap_valid in 1; trap_pc in 64; trap_cause in 64; trap_tval in 64; mret_valid in 1.
REQ-007 SHALL have ports: redirect_valid out 1; redirect_pc out 64; mstatus_o out 64; satp_o out 64; mepc_o out 64; mtvec_o out 64 (live register values).

Function
REQ-008 SHALL implement mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, satp, mcycle, plus read-only mhartid and the sstatus view (0x100).
REQ-009 SHALL run FSM IDLE->READ->WRITE->RESP->IDLE; req_ready=1 only in IDLE; request taken on req_valid&&req_ready.
REQ-010 SHALL latch op/addr/wdata at acceptance; READ captures old value; WRITE commits; resp_valid rises 3 cycles after acceptance and holds until resp_ready; RESP->IDLE on resp_valid&&resp_ready.
REQ-011 SHALL compute new value: RW = wdata; RS = old|wdata; RC = old&~wdata.
REQ-012 SHALL merge masked writes: new = (old&~M)|(val&M), M = 0x7e79bb mstatus, 0x333 mip, ~2 mtvec, 0x800000030001e000 sstatus (writes mstatus bits), all-ones otherwise.
REQ-013 SHALL skip the write (no state change) for RS/RC with wdata==0.
REQ-014 SHALL flag resp_illegal=1, with no state change and resp_rdata=0, for unmapped address, req_op=00, or a performed write to mhartid.
REQ-015 SHALL, on trap_valid in any state: mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval, mstatus.mpie<=mie, mie<=0, mpp<=2'b11; FSM->IDLE; pending access discarded; resp_valid=0 next cycle.
REQ-016 SHALL, on mret_valid without trap_valid, any state: mstatus.mie<=mpie, mpie<=1, mpp<=0; FSM->IDLE, access discarded.
REQ-017 SHALL give trap priority over mret, and trap/mret priority over a same-cycle WRITE commit.
REQ-018 SHALL pulse redirect_valid for exactly one cycle after trap/mret, redirect_pc = mepc (mret) or mtvec&~3, vectored (mtvec[0]=1, trap_cause[63]=1) mtvec&~3 + 4*trap_cause[5:0].
REQ-019 SHALL drive *_o outputs from registers, updated the cycle after the commit.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously clear all CSRs to 0 except mtvec=MTVEC_RST; FSM=IDLE; req_ready=0 during reset, 1 in first cycle after release.
REQ-021 SHALL hold resp_valid=0, resp_rdata=0, resp_illegal=0, redirect_valid=0, redirect_pc=0 at reset; reset mid-access drops the access with no commit.

Configuration
REQ-022 SHALL, with CSR_MCYCLE_EN defined, increment mcycle by 1 each cycle (wrap 2^64-1->0); a same-cycle software write wins with no increment.
REQ-023 SHALL, without CSR_MCYCLE_EN, read mcycle as 0, discard writes, report resp_illegal=0, and instantiate no counter.

Verification
REQ-024 RW mscratch 0x1234 -> resp_rdata=0 at cycle 3; following RS wdata 0 read returns 0x1234.
REQ-025 RW mstatus 0xFFFF_FFFF_FFFF_FFFF -> next read returns 0x7e79bb; RC mstatus 0x8 -> 0x7e79b3.
REQ-026 RW mhartid 1 -> resp_illegal=1, resp_rdata=0; RS mhartid wdata 0 -> legal, rdata=HARTID.
REQ-027 mstatus.mie=1, mtvec=0x8000_0001, trap_cause=0x8000_0000_0000_0007 -> redirect_pc=0x8000_001C, mie=0, mpie=1, mpp=3; mret -> redirect_pc=mepc, mie=1.
REQ-028 trap_valid in WRITE of RW mscratch 0x55 -> mscratch unchanged, no resp_valid, FSM IDLE.
REQ-029 rst_n low during RESP with resp_ready=0 -> resp_valid=0 immediately, all CSRs reset; CSR_MCYCLE_EN: mcycle reads k+1 values monotonic across back-to-back reads.

Source files
------------

// File: rtl/csr_if.sv
// CSR access bus: request channel (valid/ready) and response channel (valid/ready).
// master: requester side (drives req_*, resp_ready). slave: CSR file side.
interface csr_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 12;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_illegal
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file with a multi-cycle read-modify-write access engine
// and trap/mret handling.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (csr_if.slave) : req_valid/req_ready/req_op/req_addr/req_wdata,
//                        resp_valid/resp_ready/resp_rdata/resp_illegal
//   trap_valid, trap_pc, trap_cause, trap_tval : trap entry
//   mret_valid         : return from trap
//   redirect_valid/pc  : one-cycle fetch redirect after trap/mret
//   mstatus_o, satp_o, mepc_o, mtvec_o : live register values
//
// Optional feature: define CSR_MCYCLE_EN to build the free-running mcycle
// counter; otherwise mcycle reads as zero and writes are dropped.
module csr_file #(
  parameter logic [63:0] HARTID    = 64'd0,
  parameter logic [63:0] MTVEC_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_if.slave        bus,
  input  logic        trap_valid,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_tval,
  input  logic        mret_valid,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [63:0] mstatus_o,
  output logic [63:0] satp_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mtvec_o
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 12;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned MPP_LO   = 11;
  localparam int unsigned MPP_HI   = 12;

  localparam logic [AW-1:0] A_SSTATUS  = 12'h100;
  localparam logic [AW-1:0] A_SATP     = 12'h180;
  localparam logic [AW-1:0] A_MSTATUS  = 12'h300;
  localparam logic [AW-1:0] A_MIE      = 12'h304;
  localparam logic [AW-1:0] A_MTVEC    = 12'h305;
  localparam logic [AW-1:0] A_MSCRATCH = 12'h340;
  localparam logic [AW-1:0] A_MEPC     = 12'h341;
  localparam logic [AW-1:0] A_MCAUSE   = 12'h342;
  localparam logic [AW-1:0] A_MTVAL    = 12'h343;
  localparam logic [AW-1:0] A_MIP      = 12'h344;
  localparam logic [AW-1:0] A_MCYCLE   = 12'hB00;
  localparam logic [AW-1:0] A_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] M_MSTATUS = 64'h0000_0000_007e_79bb;
  localparam logic [XLEN-1:0] M_MIP     = 64'h0000_0000_0000_0333;
  localparam logic [XLEN-1:0] M_MTVEC   = ~64'h2;
  localparam logic [XLEN-1:0] M_SSTATUS = 64'h8000_0003_0001_e000;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_accept;
  logic            w_evt;

  logic            r_req_ready;
  logic [1:0]      r_op;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_old;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_illegal;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [XLEN-1:0] r_mstatus, r_mie, r_mip, r_mtvec, r_mscratch;
  logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_satp;
  logic [XLEN-1:0] w_mcycle;

  logic [XLEN-1:0] w_rd_val;
  logic            w_mapped;
  logic [XLEN-1:0] w_mask, w_base, w_opv, w_new;
  logic            w_do_write, w_illegal, w_commit;
  logic [XLEN-1:0] w_tvec_base, w_trap_pc;

  assign w_evt = trap_valid || mret_valid;

  // Next-state logic; trap/mret abort any access in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_state_nxt = S_READ;
          w_accept    = 1'b1;
        end
      end
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_evt) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Read mux on the latched address.
  always_comb begin
    w_rd_val = '0;
    w_mapped = 1'b1;
    case (r_addr)
      A_MSTATUS:  w_rd_val = r_mstatus;
      A_SSTATUS:  w_rd_val = r_mstatus & M_SSTATUS;
      A_MIE:      w_rd_val = r_mie;
      A_MIP:      w_rd_val = r_mip;
      A_MTVEC:    w_rd_val = r_mtvec;
      A_MSCRATCH: w_rd_val = r_mscratch;
      A_MEPC:     w_rd_val = r_mepc;
      A_MCAUSE:   w_rd_val = r_mcause;
      A_MTVAL:    w_rd_val = r_mtval;
      A_SATP:     w_rd_val = r_satp;
      A_MCYCLE:   w_rd_val = w_mcycle;
      A_MHARTID:  w_rd_val = HARTID;
      default:    w_mapped = 1'b0;
    endcase
  end

  // Write value: RMW op on the captured old value, merged under the field mask.
  // sstatus merges into the full mstatus, not into its masked view.
  always_comb begin
    w_mask = '1;
    w_base = r_old;
    case (r_addr)
      A_MSTATUS: w_mask = M_MSTATUS;
      A_SSTATUS: begin
        w_mask = M_SSTATUS;
        w_base = r_mstatus;
      end
      A_MIP:     w_mask = M_MIP;
      A_MTVEC:   w_mask = M_MTVEC;
      default:   ;
    endcase
    case (r_op)
      OP_RW:   w_opv = r_wdata;
      OP_RS:   w_opv = r_old | r_wdata;
      OP_RC:   w_opv = r_old & ~r_wdata;
      default: w_opv = r_old;
    endcase
    w_new      = (w_base & ~w_mask) | (w_opv & w_mask);
    w_do_write = (r_op == OP_RW) || (r_wdata != '0);
    w_illegal  = (r_op == 2'b00) || !w_mapped ||
                 ((r_addr == A_MHARTID) && w_do_write);
  end

  assign w_commit = (r_state == S_WRITE) && !w_evt && w_do_write && !w_illegal;

  // Vectored mode only for interrupts (cause MSB set).
  assign w_tvec_base = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_pc   = (r_mtvec[0] && trap_cause[XLEN-1])
                     ? w_tvec_base + XLEN'({trap_cause[5:0], 2'b00})
                     : w_tvec_base;

  // Access engine registers, response channel and redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready      <= 1'b0;
      r_op             <= '0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_old            <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= '0;
      r_resp_illegal   <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_req_ready      <= (w_state_nxt == S_IDLE);
      r_redirect_valid <= w_evt;
      if (trap_valid)      r_redirect_pc <= w_trap_pc;
      else if (mret_valid) r_redirect_pc <= r_mepc;
      if (w_accept) begin
        r_op    <= bus.req_op;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == S_READ) r_old <= w_rd_val;
      if (w_evt) begin
        r_resp_valid <= 1'b0;
      end else if (r_state == S_WRITE) begin
        r_resp_valid   <= 1'b1;
        r_resp_illegal <= w_illegal;
        r_resp_rdata   <= w_illegal ? '0 : r_old;
      end else if ((r_state == S_RESP) && bus.resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // CSR state: trap beats mret, both beat a software commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus  <= '0;
      r_mie      <= '0;
      r_mip      <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_satp     <= '0;
    end else if (trap_valid) begin
      r_mepc                    <= trap_pc;
      r_mcause                  <= trap_cause;
      r_mtval                   <= trap_tval;
      r_mstatus[MPIE_BIT]       <= r_mstatus[MIE_BIT];
      r_mstatus[MIE_BIT]        <= 1'b0;
      r_mstatus[MPP_HI:MPP_LO]  <= 2'b11;
    end else if (mret_valid) begin
      r_mstatus[MIE_BIT]        <= r_mstatus[MPIE_BIT];
      r_mstatus[MPIE_BIT]       <= 1'b1;
      r_mstatus[MPP_HI:MPP_LO]  <= 2'b00;
    end else if (w_commit) begin
      case (r_addr)
        A_MSTATUS, A_SSTATUS: r_mstatus <= w_new;
        A_MIE:      r_mie      <= w_new;
        A_MIP:      r_mip      <= w_new;
        A_MTVEC:    r_mtvec    <= w_new;
        A_MSCRATCH: r_mscratch <= w_new;
        A_MEPC:     r_mepc     <= w_new;
        A_MCAUSE:   r_mcause   <= w_new;
        A_MTVAL:    r_mtval    <= w_new;
        A_SATP:     r_satp     <= w_new;
        default:    ;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [XLEN-1:0] r_mcycle;

  // Free-running cycle counter; a committed software write replaces the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_mcycle <= '0;
    else if (w_commit && r_addr == A_MCYCLE) r_mcycle <= w_new;
    else                                     r_mcycle <= r_mcycle + XLEN'(1);
  end

  assign w_mcycle = r_mcycle;
`else
  assign w_mcycle = '0;
`endif

  assign bus.req_ready    = r_req_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_rdata   = r_resp_rdata;
  assign bus.resp_illegal = r_resp_illegal;
  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign mstatus_o        = r_mstatus;
  assign satp_o           = r_satp;
  assign mepc_o           = r_mepc;
  assign mtvec_o          = r_mtvec;
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: access table plus trap/mret/reset sequences.
module tb_csr_file;
  localparam logic [63:0] HART     = 64'd5;
  localparam logic [63:0] TVEC_RST = 64'h1000;

  localparam logic [1:0] RW = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RC = 2'b11;

  localparam logic [11:0] SSTATUS = 12'h100, SATP = 12'h180, MSTATUS = 12'h300;
  localparam logic [11:0] MIE = 12'h304, MTVEC = 12'h305, MSCRATCH = 12'h340;
  localparam logic [11:0] MEPC = 12'h341, MCAUSE = 12'h342, MTVAL = 12'h343;
  localparam logic [11:0] MIP = 12'h344, MCYCLE = 12'hB00, MHARTID = 12'hF14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_valid, mret_valid;
  logic [63:0] trap_pc, trap_cause, trap_tval;
  logic        redirect_valid;
  logic [63:0] redirect_pc, mstatus_o, satp_o, mepc_o, mtvec_o;

  csr_if bus();

  csr_file #(.HARTID(HART), .MTVEC_RST(TVEC_RST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_tval      (trap_tval),
    .mret_valid     (mret_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mstatus_o      (mstatus_o),
    .satp_o         (satp_o),
    .mepc_o         (mepc_o),
    .mtvec_o        (mtvec_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [1:0] op, logic [11:0] addr, logic [63:0] wd,
                              logic [63:0] rd, logic ill);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.exp_rdata = rd; v.exp_ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One full access with immediate response handshake; lat counts the
  // acceptance cycle as 0, so a correct engine yields lat == 3.
  task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic ill, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = bus.resp_rdata;
    ill = bus.resp_illegal;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic event_pulse(input logic trap, input logic mret, input logic [63:0] pc,
                             input logic [63:0] cause, input logic [63:0] tval);
    @(negedge clk);
    trap_valid = trap;
    mret_valid = mret;
    trap_pc    = pc;
    trap_cause = cause;
    trap_tval  = tval;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rd, r1;
    logic        ill;
    int          lat, n;

    vecs.push_back(mk(RW, MSCRATCH, 64'h1234, 64'h0, 1'b0));
    vecs.push_back(mk(RS, MSCRATCH, 64'h0, 64'h1234, 1'b0));
    vecs.push_back(mk(RC, MSCRATCH, 64'h4, 64'h1234, 1'b0));
    vecs.push_back(mk(RS, MSCRATCH, 64'h1, 64'h1230, 1'b0));
    vecs.push_back(mk(RW, MSCRATCH, 64'h77, 64'h1231, 1'b0));
    vecs.push_back(mk(2'b00, MSCRATCH, 64'hff, 64'h0, 1'b1));
    vecs.push_back(mk(RS, MSCRATCH, 64'h0, 64'h77, 1'b0));
    vecs.push_back(mk(RW, 12'h7C0, 64'h1, 64'h0, 1'b1));
    vecs.push_back(mk(RW, MSTATUS, '1, 64'h0, 1'b0));
    vecs.push_back(mk(RC, MSTATUS, 64'h8, 64'h7e79bb, 1'b0));
    vecs.push_back(mk(RS, MSTATUS, 64'h0, 64'h7e79b3, 1'b0));
    vecs.push_back(mk(RS, SSTATUS, 64'h0, 64'h6000, 1'b0));
    vecs.push_back(mk(RC, SSTATUS, 64'h2000, 64'h6000, 1'b0));
    vecs.push_back(mk(RS, MSTATUS, 64'h0, 64'h7e59b3, 1'b0));
    vecs.push_back(mk(RW, MIP, 64'hffff, 64'h0, 1'b0));
    vecs.push_back(mk(RS, MIP, 64'h0, 64'h333, 1'b0));
    vecs.push_back(mk(RW, MTVEC, 64'hffff_ffff, TVEC_RST, 1'b0));
    vecs.push_back(mk(RS, MTVEC, 64'h0, 64'hffff_fffd, 1'b0));
    vecs.push_back(mk(RW, MHARTID, 64'h1, 64'h0, 1'b1));
    vecs.push_back(mk(RS, MHARTID, 64'h0, HART, 1'b0));
    vecs.push_back(mk(RC, MHARTID, 64'h0, HART, 1'b0));
    vecs.push_back(mk(RS, MHARTID, 64'h1, 64'h0, 1'b1));
    vecs.push_back(mk(RW, SATP, 64'habcd, 64'h0, 1'b0));
    vecs.push_back(mk(RS, SATP, 64'h0, 64'habcd, 1'b0));
    vecs.push_back(mk(RW, MIE, '1, 64'h0, 1'b0));
    vecs.push_back(mk(RC, MIE, 64'hf0, '1, 1'b0));
    vecs.push_back(mk(RS, MIE, 64'h0, 64'hffff_ffff_ffff_ff0f, 1'b0));
    vecs.push_back(mk(RW, MEPC, 64'h2000, 64'h0, 1'b0));
    vecs.push_back(mk(RW, MCAUSE, 64'h5, 64'h0, 1'b0));
    vecs.push_back(mk(RW, MTVAL, 64'h9, 64'h0, 1'b0));
    vecs.push_back(mk(RS, MEPC, 64'h0, 64'h2000, 1'b0));
    vecs.push_back(mk(RW, MTVEC, 64'h8000_0001, 64'hffff_fffd, 1'b0));
    vecs.push_back(mk(RW, MSTATUS, 64'h8, 64'h7e59b3, 1'b0));
    vecs.push_back(mk(RS, MSTATUS, 64'h0, 64'h8, 1'b0));

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    trap_valid = 1'b0; mret_valid = 1'b0;
    trap_pc = '0; trap_cause = '0; trap_tval = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_illegal", 64'(bus.resp_illegal), 64'd0);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_mstatus", mstatus_o, 64'd0);
    chk("rst_mtvec", mtvec_o, TVEC_RST);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Table-driven accesses
    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, ill, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_illegal", i), 64'(ill), 64'(vecs[i].exp_ill));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
    end
    chk("satp_o", satp_o, 64'habcd);
    chk("mtvec_o", mtvec_o, 64'h8000_0001);

    // Vectored interrupt trap
    event_pulse(1'b1, 1'b0, 64'h4444, 64'h8000_0000_0000_0007, 64'h99);
    chk("trap1_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("trap1_redirect_pc", redirect_pc, 64'h8000_001c);
    chk("trap1_mstatus", mstatus_o, 64'h1880);
    chk("trap1_mepc", mepc_o, 64'h4444);
    @(posedge clk); #1;
    chk("trap1_redirect_pulse", 64'(redirect_valid), 64'd0);
    access(RS, MCAUSE, 64'h0, rd, ill, lat);
    chk("trap1_mcause", rd, 64'h8000_0000_0000_0007);
    access(RS, MTVAL, 64'h0, rd, ill, lat);
    chk("trap1_mtval", rd, 64'h99);

    // mret
    event_pulse(1'b0, 1'b1, 64'h0, 64'h0, 64'h0);
    chk("mret_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("mret_redirect_pc", redirect_pc, 64'h4444);
    chk("mret_mstatus", mstatus_o, 64'h88);

    // Exception (cause MSB clear) goes to the base even in vectored mode
    event_pulse(1'b1, 1'b0, 64'h5000, 64'h7, 64'h0);
    chk("trap2_redirect_pc", redirect_pc, 64'h8000_0000);
    chk("trap2_mstatus", mstatus_o, 64'h1880);

    // Trap during WRITE of RW mscratch: commit must be dropped
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = RW; bus.req_addr = MSCRATCH; bus.req_wdata = 64'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    trap_valid = 1'b1; trap_pc = 64'h7000; trap_cause = 64'h2; trap_tval = 64'h0;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_redirect_pc", redirect_pc, 64'h8000_0000);
    chk("abort_mstatus", mstatus_o, 64'h1800);
    @(posedge clk); #1;
    chk("abort_resp_valid_later", 64'(bus.resp_valid), 64'd0);
    access(RS, MSCRATCH, 64'h0, rd, ill, lat);
    chk("abort_mscratch", rd, 64'h77);

    // Trap wins over a same-cycle mret
    event_pulse(1'b1, 1'b1, 64'h6000, 64'h8000_0000_0000_0003, 64'h0);
    chk("prio_redirect_pc", redirect_pc, 64'h8000_000c);
    chk("prio_mepc", mepc_o, 64'h6000);
    chk("prio_mstatus", mstatus_o, 64'h1800);

    // Reset while a response is held (resp_ready low)
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = RW; bus.req_addr = MSCRATCH; bus.req_wdata = 64'hab;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("hold_resp_valid", 64'(bus.resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_mstatus", mstatus_o, 64'd0);
    chk("midrst_mepc", mepc_o, 64'd0);
    chk("midrst_satp", satp_o, 64'd0);
    chk("midrst_mtvec", mtvec_o, TVEC_RST);
    chk("midrst_redirect_pc", redirect_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(RS, MSCRATCH, 64'h0, rd, ill, lat);
    chk("midrst_mscratch", rd, 64'h0);

`ifdef CSR_MCYCLE_EN
    access(RS, MCYCLE, 64'h0, rd, ill, lat);
    r1 = rd;
    access(RS, MCYCLE, 64'h0, rd, ill, lat);
    chk("mcycle_nonzero", 64'(r1 != 64'd0), 64'd1);
    chk("mcycle_monotonic", 64'(rd > r1), 64'd1);
    chk("mcycle_illegal", 64'(ill), 64'd0);
`else
    access(RW, MCYCLE, 64'h5, rd, ill, lat);
    chk("mcycle_rw_rdata", rd, 64'h0);
    chk("mcycle_rw_illegal", 64'(ill), 64'd0);
    access(RS, MCYCLE, 64'h0, rd, ill, lat);
    r1 = rd;
    chk("mcycle_read_zero", r1, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
